// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port with
// ownership held for a whole cyc, plus a stall watchdog that aborts hung slaves.
module wishbone_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_MASTERS-1:0]                m_cyc,
    input  logic [NUM_MASTERS-1:0]                m_stb,
    input  logic [NUM_MASTERS-1:0]                m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_w,
    output logic [DATA_WIDTH-1:0]                 m_dat_r,
    output logic [NUM_MASTERS-1:0]                m_ack,
    output logic [NUM_MASTERS-1:0]                m_err,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [ADDR_WIDTH-1:0]                 s_adr,
    output logic [DATA_WIDTH/8-1:0]               s_sel,
    output logic [DATA_WIDTH-1:0]                 s_dat_w,
    input  logic [DATA_WIDTH-1:0]                 s_dat_r,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    output logic [NUM_MASTERS-1:0]                grant,
    output logic                                  timeout_pulse
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [CW-1:0]          wd_q, wd_d;
    logic                   tmo_q, tmo_d;

    logic owned, owner_cyc, owner_stb, wd_hit;
    logic [PW-1:0] next_ptr;

    assign owned     = (state_q == OWNED);
    assign owner_cyc = m_cyc[owner_q];
    assign owner_stb = m_stb[owner_q] & owner_cyc;
    assign wd_hit    = (TIMEOUT_CYCLES != 0) && (wd_q == CW'(TIMEOUT_CYCLES - 1));
    assign next_ptr  = (owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

    // Slave side sees the owner only in OWNED; IDLE and ABORT present a quiet bus.
    always_comb begin
        s_cyc         = owned & owner_cyc;
        s_stb         = owned & owner_stb;
        s_we          = owned & m_we[owner_q];
        s_adr         = owned ? m_adr[owner_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        s_sel         = owned ? m_sel[owner_q*SW +: SW] : '0;
        s_dat_w       = owned ? m_dat_w[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        m_dat_r       = s_dat_r;
        m_ack         = (owned & s_ack) ? grant_q : '0;
        m_err         = ((owned & s_err) | tmo_q) ? grant_q : '0;
        grant         = grant_q;
        timeout_pulse = tmo_q;
    end

    always_comb begin
        int  win;
        logic found;
        // NOTE: every next-state signal gets a default first so no path leaves
        // a variable unassigned, which would infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        tmo_d   = 1'b0;
        win     = 0;
        found   = 1'b0;

        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && m_cyc[(int'(ptr_q) + i) % NUM_MASTERS]) begin
                        found = 1'b1;
                        win   = (int'(ptr_q) + i) % NUM_MASTERS;
                    end
                end
                if (found) begin
                    state_d      = OWNED;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = PW'(win);
                    wd_d         = '0;
                end
            end
            OWNED: begin
                // Release outranks both ack and the watchdog threshold.
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    wd_d    = '0;
                end else if (s_ack || s_err || !owner_stb) begin
                    wd_d = '0;
                end else if (wd_hit) begin
                    state_d = ABORT;
                    tmo_d   = 1'b1;
                    wd_d    = '0;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: expectations are queued as stimulus is
// driven and drained against the DUT at the sampling point of each cycle.
module tb_wishbone_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*AW-1:0]   m_adr;
    logic [N*SW-1:0]   m_sel;
    logic [N*DW-1:0]   m_dat_w;
    logic [DW-1:0]     m_dat_r;
    logic [N-1:0]      m_ack, m_err;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [SW-1:0]     s_sel;
    logic [DW-1:0]     s_dat_w;
    logic [DW-1:0]     s_dat_r;
    logic              s_ack, s_err;
    logic [N-1:0]      grant;
    logic              timeout_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    wishbone_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "simulation time limit reached");
    end

    function automatic logic [63:0] probe(input string tag);
        case (tag)
            "grant":   return 64'(grant);
            "s_cyc":   return 64'(s_cyc);
            "s_stb":   return 64'(s_stb);
            "s_we":    return 64'(s_we);
            "s_adr":   return 64'(s_adr);
            "s_sel":   return 64'(s_sel);
            "s_dat_w": return 64'(s_dat_w);
            "m_dat_r": return 64'(m_dat_r);
            "m_ack":   return 64'(m_ack);
            "m_err":   return 64'(m_err);
            "tmo":     return 64'(timeout_pulse);
            default:   return 64'hx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = probe(e.tag);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        drain();
    endtask

    task automatic drive_m(input int i, input logic cyc, input logic stb,
                           input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat);
        m_cyc[i]               = cyc;
        m_stb[i]               = stb;
        m_we[i]                = we;
        m_adr[i*AW +: AW]      = adr;
        m_sel[i*SW +: SW]      = '1;
        m_dat_w[i*DW +: DW]    = dat;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_cyc   = '0; m_stb = '0; m_we = '0;
        m_adr   = '0; m_sel = '0; m_dat_w = '0;
        s_dat_r = 32'h1234_5678;
        s_ack   = 1'b0; s_err = 1'b0;

        repeat (2) @(posedge clk);
        expect_v("grant", 0); expect_v("s_cyc", 0); expect_v("m_ack", 0);
        expect_v("m_err", 0); expect_v("tmo", 0);
        settle();
        tick(); rst_n = 1'b1;

        // Single master write, slave acks two cycles after s_cyc rises.
        tick(); drive_m(0, 1, 1, 1, 32'h0001_0000, 32'hDEAD_BEEF);
        expect_v("s_cyc", 0); expect_v("grant", 0);
        settle();
        tick();
        expect_v("grant", 1); expect_v("s_cyc", 1); expect_v("s_we", 1);
        expect_v("s_adr", 64'h0001_0000); expect_v("s_dat_w", 64'hDEAD_BEEF);
        expect_v("s_sel", 64'hF); expect_v("m_ack", 0); expect_v("m_dat_r", 64'h1234_5678);
        settle();
        tick(); expect_v("m_ack", 0); settle();
        tick(); s_ack = 1'b1; expect_v("m_ack", 64'b01); settle();
        tick(); s_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0001_0000, 32'hDEAD_BEEF);
        expect_v("m_ack", 0); expect_v("s_cyc", 0); expect_v("grant", 1);
        settle();
        tick(); expect_v("grant", 0); settle();

        // Fresh reset so contention starts from pointer 0.
        tick(); rst_n = 1'b0; expect_v("grant", 0); settle();
        tick(); rst_n = 1'b1;

        tick();
        drive_m(0, 1, 1, 0, 32'h0001_0000, 32'h0);
        drive_m(1, 1, 1, 0, 32'h0000_2000, 32'h0);
        expect_v("grant", 0);
        settle();
        tick(); s_ack = 1'b1;
        expect_v("grant", 64'b01); expect_v("s_adr", 64'h0001_0000); expect_v("m_ack", 64'b01);
        settle();
        tick(); s_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        expect_v("grant", 64'b01); expect_v("m_ack", 0);
        settle();
        tick(); expect_v("grant", 0); expect_v("s_cyc", 0); settle();
        tick(); expect_v("grant", 64'b10); expect_v("s_adr", 64'h0000_2000); settle();
        tick(); s_ack = 1'b1; expect_v("m_ack", 64'b10); settle();
        tick(); s_ack = 1'b0; drive_m(1, 0, 0, 0, 32'h0, 32'h0);
        expect_v("grant", 64'b10); expect_v("m_ack", 0);
        settle();
        tick();
        drive_m(0, 1, 1, 0, 32'h0001_0000, 32'h0);
        drive_m(1, 1, 1, 0, 32'h0000_2000, 32'h0);
        expect_v("grant", 0);
        settle();
        tick(); expect_v("grant", 64'b01); settle();
        tick(); drive_m(0, 0, 0, 0, 32'h0, 32'h0); drive_m(1, 0, 0, 0, 32'h0, 32'h0);
        expect_v("s_cyc", 0);
        settle();
        tick();
        drive_m(0, 1, 1, 0, 32'h0001_0000, 32'h0);
        drive_m(1, 1, 1, 1, 32'h0000_2000, 32'h0);
        expect_v("grant", 0);
        settle();
        tick(); expect_v("grant", 64'b10); settle();

        // Locked burst by m1 while m0 keeps requesting.
        for (int b = 0; b < 4; b++) begin
            tick(); s_ack = 1'b1;
            drive_m(1, 1, 1, 1, 32'h0000_2000 + 32'(4 * b), 32'hA000_0000 + 32'(b));
            expect_v("grant", 64'b10); expect_v("m_ack", 64'b10);
            expect_v("s_adr", 64'h0000_2000 + 64'(4 * b));
            settle();
        end
        tick(); s_ack = 1'b0; drive_m(1, 0, 0, 0, 32'h0, 32'h0);
        expect_v("grant", 64'b10); expect_v("m_ack", 0);
        settle();
        tick(); expect_v("grant", 0); settle();
        tick(); expect_v("grant", 64'b01); settle();
        tick(); drive_m(0, 0, 0, 0, 32'h0, 32'h0); expect_v("s_cyc", 0); settle();

        // Watchdog abort: slave never acks m0.
        tick(); drive_m(0, 1, 1, 0, 32'h0000_3000, 32'h0); expect_v("grant", 0); settle();
        tick(); drive_m(1, 1, 1, 0, 32'h0000_4000, 32'h0);
        expect_v("grant", 64'b01); expect_v("s_stb", 1);
        settle();
        for (int k = 1; k < 8; k++) begin
            tick(); expect_v("m_err", 0); expect_v("tmo", 0); expect_v("s_cyc", 1); settle();
        end
        tick(); s_ack = 1'b1;
        expect_v("m_err", 64'b01); expect_v("tmo", 1); expect_v("s_cyc", 0);
        expect_v("s_stb", 0); expect_v("m_ack", 0); expect_v("grant", 64'b01);
        settle();
        tick(); s_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        expect_v("m_err", 0); expect_v("tmo", 0); expect_v("grant", 64'b01);
        settle();
        tick(); expect_v("grant", 0); settle();
        tick(); expect_v("grant", 64'b10); expect_v("s_adr", 64'h0000_4000); settle();
        tick(); drive_m(1, 0, 0, 0, 32'h0, 32'h0); expect_v("s_cyc", 0); settle();

        // Ack on the threshold cycle wins; then release on a later threshold.
        tick(); drive_m(0, 1, 1, 0, 32'h0000_5000, 32'h0); expect_v("grant", 0); settle();
        tick(); expect_v("grant", 64'b01); settle();
        for (int k = 1; k < 7; k++) begin
            tick(); expect_v("m_err", 0); settle();
        end
        tick(); s_ack = 1'b1; expect_v("m_ack", 64'b01); expect_v("m_err", 0); settle();
        tick(); s_ack = 1'b0;
        expect_v("m_err", 0); expect_v("tmo", 0); expect_v("s_cyc", 1);
        settle();
        for (int k = 9; k < 15; k++) begin
            tick(); expect_v("tmo", 0); settle();
        end
        tick(); drive_m(0, 0, 0, 0, 32'h0, 32'h0); expect_v("tmo", 0); settle();
        tick(); expect_v("grant", 0); expect_v("tmo", 0); expect_v("m_err", 0); settle();

        // Asynchronous reset while m1 owns the bus.
        tick(); drive_m(1, 1, 1, 0, 32'h0000_6000, 32'h0); expect_v("grant", 0); settle();
        tick(); expect_v("grant", 64'b10); expect_v("s_cyc", 1); settle();
        tick(); #2 rst_n = 1'b0; #1;
        expect_v("grant", 0); expect_v("s_cyc", 0); expect_v("s_stb", 0);
        drain();
        @(negedge clk);
        tick(); rst_n = 1'b1; s_ack = 1'b1;
        drive_m(0, 1, 1, 0, 32'h0000_7000, 32'h0);
        expect_v("grant", 0); expect_v("m_ack", 0); expect_v("m_err", 0);
        settle();
        tick(); s_ack = 1'b0; expect_v("grant", 64'b01); expect_v("s_adr", 64'h0000_7000); settle();

        tick(); m_cyc = '0; m_stb = '0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
